// File: rtl/spi_adc_responder_pkg.sv
// Shared constants and FSM state type for the SPI ADC responder.
package spi_adc_responder_pkg;

    localparam int                        ADC_DATA_WIDTH = 16;
    localparam logic [ADC_DATA_WIDTH-1:0] ADC_IDLE_CODE  = 16'h8000;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } spi_resp_state_t;

endpackage

// File: rtl/spi_adc_responder_if.sv
// Sample-stream handshake plus SPI pins and status of the ADC responder.
interface spi_adc_responder_if
    import spi_adc_responder_pkg::*;
#(
    parameter int DATA_WIDTH = ADC_DATA_WIDTH
) ();

    logic [DATA_WIDTH-1:0] sample;
    logic                  sample_valid;
    logic                  sample_ready;
    logic                  chip_clk;
    logic                  chip_sel;
    logic                  chip_data;
    logic                  frame_done;
    logic [15:0]           underrun_count;

    modport master (
        output sample, sample_valid, chip_clk, chip_sel,
        input  sample_ready, chip_data, frame_done, underrun_count
    );

    modport slave (
        input  sample, sample_valid, chip_clk, chip_sel,
        output sample_ready, chip_data, frame_done, underrun_count
    );

endinterface

// File: rtl/spi_adc_responder_fifo.sv
// Synchronous sample FIFO; pointers carry one extra wrap bit to tell full from empty.
module spi_adc_responder_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                  clk_100mhz,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  full,
    output logic                  empty
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/spi_adc_responder.sv
// SPI peripheral model of the ADC: serves one buffered sample per CS frame, MSB first on CIPO.
// States: IDLE wait cs_fall | LOAD pop head (or idle code) into shift reg | SHIFT one bit per sclk_fall
module spi_adc_responder
    import spi_adc_responder_pkg::*;
#(
    parameter int                    DATA_WIDTH  = ADC_DATA_WIDTH,
    parameter int                    FIFO_DEPTH  = 4,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] IDLE_CODE   = ADC_IDLE_CODE
) (
    input logic                clk_100mhz,
    input logic                rst,
    spi_adc_responder_if.slave bus
);

    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

    logic                  cs_s, sclk_s, cs_prev, sclk_prev;
    logic                  cs_fall, cs_rise, sclk_fall;
    logic                  fifo_full, fifo_empty, fifo_pop;
    logic [DATA_WIDTH-1:0] fifo_head, load_word;

    spi_resp_state_t       state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0]      bit_cnt;
    logic [15:0]           underrun_cnt;
    logic                  chip_data_q, frame_done_q;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign cs_s   = bus.chip_sel;
            assign sclk_s = bus.chip_clk;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] cs_sync, sclk_sync;
            always_ff @(posedge clk_100mhz or posedge rst) begin
                if (rst) begin
                    cs_sync   <= '1;
                    sclk_sync <= '1;
                end else begin
                    cs_sync[0]   <= bus.chip_sel;
                    sclk_sync[0] <= bus.chip_clk;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        cs_sync[i]   <= cs_sync[i-1];
                        sclk_sync[i] <= sclk_sync[i-1];
                    end
                end
            end
            assign cs_s   = cs_sync[SYNC_STAGES-1];
            assign sclk_s = sclk_sync[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            cs_prev   <= 1'b1;
            sclk_prev <= 1'b1;
        end else begin
            cs_prev   <= cs_s;
            sclk_prev <= sclk_s;
        end
    end

    assign cs_fall   = cs_prev & ~cs_s;
    assign cs_rise   = ~cs_prev & cs_s;
    assign sclk_fall = sclk_prev & ~sclk_s;

    // The head is consumed on entry to a frame even if CS aborts it.
    assign fifo_pop  = (state == LOAD);
    assign load_word = fifo_empty ? IDLE_CODE : fifo_head;

    spi_adc_responder_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk_100mhz (clk_100mhz),
        .rst        (rst),
        .push       (bus.sample_valid),
        .push_data  (bus.sample),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            underrun_cnt <= '0;
            chip_data_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    chip_data_q <= 1'b0;
                    if (cs_fall) state <= LOAD;
                end
                LOAD: begin
                    shift_reg <= load_word;
                    bit_cnt   <= '0;
                    if (fifo_empty && underrun_cnt != 16'hFFFF)
                        underrun_cnt <= underrun_cnt + 16'd1;
                    if (cs_rise) begin
                        state       <= IDLE;
                        chip_data_q <= 1'b0;
                    end else begin
                        state       <= SHIFT;
                        chip_data_q <= load_word[DATA_WIDTH-1];
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state        <= IDLE;
                        chip_data_q  <= 1'b0;
                        frame_done_q <= (bit_cnt >= CNT_W'(DATA_WIDTH - 1));
                    end else if (sclk_fall) begin
                        shift_reg   <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
                        chip_data_q <= shift_reg[DATA_WIDTH-2];
                        if (bit_cnt != '1) bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sample_ready   = ~fifo_full;
    assign bus.chip_data      = chip_data_q;
    assign bus.frame_done     = frame_done_q;
    assign bus.underrun_count = underrun_cnt;

endmodule
